// File: rtl/iec_sd_arbiter.sv
// rtl/iec_sd_arbiter.sv - round-robin sharing of the host SD block channel between IEC drive units
module iec_sd_arbiter #(
  parameter int          NDRIVES = 2,
  parameter logic [23:0] TIMEOUT = 24'd12000000
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [32*NDRIVES-1:0]   req_lba,
  input  logic [NDRIVES-1:0]      req_rd,
  input  logic [NDRIVES-1:0]      req_wr,
  output logic [NDRIVES-1:0]      req_ack,
  output logic [NDRIVES-1:0]      req_buff_wr,
  input  logic [8*NDRIVES-1:0]    req_buff_din,
  output logic [31:0]             sd_lba,
  output logic                    sd_rd,
  output logic                    sd_wr,
  input  logic                    sd_ack,
  input  logic                    sd_buff_wr,
  output logic [7:0]              sd_buff_din,
  output logic                    busy,
  output logic [1:0]              grant,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_RELEASE} state_t;

  state_t      state, state_nxt;
  logic [31:0] lba_arr [4];
  logic [7:0]  din_arr [4];
  logic [3:0]  rd4, pend4, ack4, bw4;
  logic [2:0]  idx3;
  logic [1:0]  pick_idx;
  logic        pick_valid, issue_go, wd_hit;
  logic [23:0] wd_cnt;

  // Pad per-drive buses to four slots so a 2-bit grant can index them directly.
  for (genvar g = 0; g < 4; g++) begin : g_pad
    if (g < NDRIVES) begin : g_on
      assign lba_arr[g] = req_lba[32*g +: 32];
      assign din_arr[g] = req_buff_din[8*g +: 8];
      assign rd4[g]     = req_rd[g];
      assign pend4[g]   = req_rd[g] | req_wr[g];
    end else begin : g_off
      assign lba_arr[g] = '0;
      assign din_arr[g] = '0;
      assign rd4[g]     = 1'b0;
      assign pend4[g]   = 1'b0;
    end
  end

  // Search downward so the nearest index after grant is the one left standing.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = grant;
    idx3       = '0;
    for (int k = NDRIVES; k >= 1; k--) begin
      idx3 = {1'b0, grant} + 3'(k);
      if (idx3 >= 3'(NDRIVES)) idx3 = idx3 - 3'(NDRIVES);
      if (pend4[idx3[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = idx3[1:0];
      end
    end
  end

  // A stale sd_ack left over from a reset mid-transfer blocks new issues.
  assign issue_go = (state == S_IDLE) && pick_valid && !sd_ack;
  assign wd_hit   = (wd_cnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (issue_go) state_nxt = S_ISSUE;
      S_ISSUE:   if (sd_ack) state_nxt = S_XFER;
                 else if (wd_hit) state_nxt = S_RELEASE;
      S_XFER:    if (!sd_ack) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack4        = '0;
    bw4         = '0;
    sd_buff_din = '0;
    busy        = (state != S_IDLE);
    if (state == S_ISSUE || state == S_XFER) begin
      ack4[grant] = sd_ack;
      bw4[grant]  = sd_buff_wr;
      sd_buff_din = din_arr[grant];
    end
  end

  assign req_ack     = ack4[NDRIVES-1:0];
  assign req_buff_wr = bw4[NDRIVES-1:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      grant       <= 2'(NDRIVES-1);
      sd_lba      <= '0;
      sd_rd       <= 1'b0;
      sd_wr       <= 1'b0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue_go) begin
            grant  <= pick_idx;
            sd_lba <= lba_arr[pick_idx];
            sd_rd  <= rd4[pick_idx];
            sd_wr  <= ~rd4[pick_idx];
            wd_cnt <= '0;
          end
        end
        S_ISSUE: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
          end else if (wd_hit) begin
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// tb/tb_iec_sd_arbiter.sv - scoreboard bench for iec_sd_arbiter with two drives
module tb_iec_sd_arbiter;
  localparam int ND = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   req_lba = '0;
  logic [ND-1:0] req_rd = '0;
  logic [ND-1:0] req_wr = '0;
  logic [ND-1:0] req_ack;
  logic [ND-1:0] req_buff_wr;
  logic [15:0]   req_buff_din = {8'hA5, 8'h3C};
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack = 1'b0;
  logic          sd_buff_wr = 1'b0;
  logic [7:0]    sd_buff_din;
  logic          busy;
  logic [1:0]    grant;
  logic          timeout_err;

  iec_sd_arbiter #(.NDRIVES(ND), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_lba(req_lba), .req_rd(req_rd), .req_wr(req_wr),
    .req_ack(req_ack), .req_buff_wr(req_buff_wr), .req_buff_din(req_buff_din),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          drv;
    logic [31:0] lba;
    bit          rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, mon_cmp = 0, mon_bad = 0;
  bit   prev_issue = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    mon_cmp++;
    if (act !== exp) begin
      mon_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Each new host request is matched against the next expected transaction.
  always @(negedge clk_sys) begin
    exp_t e;
    if ((sd_rd | sd_wr) && !prev_issue) begin
      if (exp_q.size() == 0) begin
        mon_cmp++;
        mon_bad++;
        $display("FAIL unexpected_issue: got lba 0x%0h grant %0d, required no request", sd_lba, grant);
      end else begin
        e = exp_q.pop_front();
        mon_check("issue_grant", 32'(grant), 32'(e.drv));
        mon_check("issue_lba", sd_lba, e.lba);
        mon_check("issue_op", {30'd0, sd_rd, sd_wr}, e.rd ? 32'd2 : 32'd1);
      end
    end
    prev_issue = sd_rd | sd_wr;
  end

  task automatic do_reset();
    reset_n    = 1'b0;
    req_rd     = '0;
    req_wr     = '0;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!(sd_rd | sd_wr) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (!(sd_rd | sd_wr)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_wait: no sd_rd/sd_wr within 200 cycles, required a request");
    end
  endtask

  task automatic serve(input int drv, input int wait_cyc, input int nstrobe, input bit drop);
    int         own = 0, other = 0;
    logic [7:0] din_exp;
    din_exp = (drv == 0) ? 8'h3C : 8'hA5;
    wait_issue();
    repeat (wait_cyc) @(negedge clk_sys);
    check("req_held_until_ack", {31'd0, sd_rd | sd_wr}, 32'd1);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check("req_ack", 32'(req_ack), 32'(1 << drv));
    check("req_cleared_after_ack", {30'd0, sd_rd, sd_wr}, 32'd0);
    check("buff_din", 32'(sd_buff_din), 32'(din_exp));
    if (drop) begin
      if (req_rd[drv]) req_rd[drv] = 1'b0;
      else             req_wr[drv] = 1'b0;
    end
    for (int i = 0; i < nstrobe; i++) begin
      sd_buff_wr = 1'b1;
      #1;
      if (req_buff_wr[drv]) own++;
      if (req_buff_wr[1-drv]) other++;
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    check("buff_wr_own", 32'(own), 32'(nstrobe));
    check("buff_wr_other", 32'(other), 32'd0);
    sd_ack = 1'b0;
    @(negedge clk_sys);
    check("release_busy", {31'd0, busy}, 32'd1);
    @(negedge clk_sys);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_buff_din", 32'(sd_buff_din), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int hi, te, n;

    do_reset();
    check("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_grant", 32'(grant), 32'd1);
    check("rst_buff_din", 32'(sd_buff_din), 32'd0);

    // Single read from drive 0 with a 256-byte transfer.
    req_lba[31:0] = 32'h0000_012A;
    req_rd[0]     = 1'b1;
    exp_q.push_back('{drv: 0, lba: 32'h0000_012A, rd: 1'b1});
    @(negedge clk_sys);
    check("rd_one_cycle_latency", {31'd0, sd_rd}, 32'd1);
    check("busy_in_issue", {31'd0, busy}, 32'd1);
    serve(0, 5, 256, 1'b1);

    // Both drives hold reads: grants alternate 0,1,0,1.
    do_reset();
    req_lba = {32'h0000_0200, 32'h0000_0100};
    req_rd  = 2'b11;
    exp_q.push_back('{drv: 0, lba: 32'h0000_0100, rd: 1'b1});
    exp_q.push_back('{drv: 1, lba: 32'h0000_0200, rd: 1'b1});
    exp_q.push_back('{drv: 0, lba: 32'h0000_0100, rd: 1'b1});
    exp_q.push_back('{drv: 1, lba: 32'h0000_0200, rd: 1'b1});
    serve(0, 2, 4, 1'b0);
    serve(1, 1, 4, 1'b0);
    serve(0, 3, 4, 1'b0);
    req_rd[0] = 1'b0;
    serve(1, 2, 4, 1'b1);

    // Drive 1 write with read-back data.
    do_reset();
    req_lba[63:32] = 32'h0000_0400;
    req_wr[1]      = 1'b1;
    exp_q.push_back('{drv: 1, lba: 32'h0000_0400, rd: 1'b0});
    check("idle_din_zero", 32'(sd_buff_din), 32'd0);
    serve(1, 2, 8, 1'b1);

    // Drive 0 never acknowledged; drive 1 waits behind it.
    do_reset();
    req_lba = {32'h0000_0B00, 32'h0000_0A00};
    req_rd  = 2'b11;
    exp_q.push_back('{drv: 0, lba: 32'h0000_0A00, rd: 1'b1});
    exp_q.push_back('{drv: 1, lba: 32'h0000_0B00, rd: 1'b1});
    exp_q.push_back('{drv: 0, lba: 32'h0000_0A00, rd: 1'b1});
    @(negedge clk_sys);
    hi = 0; te = 0; n = 0;
    while (sd_rd && n < 300) begin
      if (timeout_err) te++;
      hi++;
      @(negedge clk_sys);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      if (timeout_err) te++;
      @(negedge clk_sys);
    end
    check("timeout_rd_cycles", 32'(hi), 32'd100);
    check("timeout_err_pulses", 32'(te), 32'd1);
    serve(1, 3, 4, 1'b1);
    serve(0, 2, 4, 1'b1);

    // Reset in the middle of a transfer with sd_ack still high.
    do_reset();
    req_lba[31:0] = 32'h0000_0777;
    req_rd[0]     = 1'b1;
    exp_q.push_back('{drv: 0, lba: 32'h0000_0777, rd: 1'b1});
    wait_issue();
    sd_ack = 1'b1;
    @(negedge clk_sys);
    check("xfer_ack_before_reset", 32'(req_ack), 32'd1);
    reset_n = 1'b0;
    #1;
    check("reset_req_ack", 32'(req_ack), 32'd0);
    check("reset_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_grant", 32'(grant), 32'd1);
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_q.push_back('{drv: 0, lba: 32'h0000_0777, rd: 1'b1});
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      if (sd_rd | sd_wr) hi++;
      if (i == 2) begin
        sd_buff_wr = 1'b1;
        #1;
        check("idle_ack_no_buff_wr", 32'(req_buff_wr), 32'd0);
        check("idle_ack_no_req_ack", 32'(req_ack), 32'd0);
        sd_buff_wr = 1'b0;
      end
    end
    check("no_issue_while_ack_high", 32'(hi), 32'd0);
    sd_ack = 1'b0;
    serve(0, 1, 0, 1'b1);

    // Read and write asserted together: read first, write later.
    do_reset();
    req_lba[31:0] = 32'h0000_0055;
    req_rd[0]     = 1'b1;
    req_wr[0]     = 1'b1;
    exp_q.push_back('{drv: 0, lba: 32'h0000_0055, rd: 1'b1});
    exp_q.push_back('{drv: 0, lba: 32'h0000_0055, rd: 1'b0});
    serve(0, 1, 2, 1'b1);
    serve(0, 1, 2, 1'b1);

    repeat (3) @(negedge clk_sys);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    n_cmp += mon_cmp;
    n_bad += mon_bad;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
